// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_SRC null-terminated message sources.
// Grant is held from start request until the UART reports idle again; a UART that never goes busy is aborted.
module uart_msg_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int ADDR_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req_i,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic [NUM_SRC-1:0]   done_o,
  output logic                 err_o,
  input  logic [ADDR_W-1:0]    uart_addr_i,
  output logic [ADDR_W-1:0]    src_addr_o,
  input  logic [8*NUM_SRC-1:0] src_data_i,
  output logic [7:0]           uart_data_o,
  output logic                 uart_start_o,
  input  logic                 uart_idle_i
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [NUM_SRC-1:0] GRANT_ONE = NUM_SRC'(1);

  // state       | meaning
  // S_IDLE      | no owner, pick next requester when the UART is idle
  // S_START     | start held high, waiting for the UART to go busy (bounded)
  // S_WAIT_DONE | UART busy with the granted message
  // S_FINISH    | done pulse for the owner, grant released at end of cycle
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_FINISH} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [NUM_SRC-1:0] done_q;
  logic               err_q;
  logic               start_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;

  // Scan last+1, last+2, ... with wrap so the previous owner gets lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = last_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = (cand == IDX_W'(NUM_SRC - 1)) ? '0 : cand + 1'b1;
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_found && uart_idle_i) begin
            grant_q <= GRANT_ONE << sel_idx;
            gidx_q  <= sel_idx;
            cnt_q   <= '0;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (!uart_idle_i) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= S_WAIT_DONE;
          end else if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
            err_q   <= 1'b1;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
            start_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (uart_idle_i) begin
            done_q  <= grant_q;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          grant_q <= '0;
          last_q  <= gidx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    uart_data_o = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) uart_data_o = src_data_i[8*i +: 8];
    end
  end

  assign src_addr_o   = uart_addr_i;
  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign uart_start_o = start_q;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-phase reference model and a simple UART model.
module tb_uart_msg_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int BT = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            err;
  logic [AW-1:0]   uart_addr;
  logic [AW-1:0]   src_addr;
  logic [8*N-1:0]  src_data;
  logic [7:0]      uart_data;
  logic            uart_start;
  logic            uart_idle;

  uart_msg_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .BUSY_TIMEOUT(BT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .grant_o      (grant),
    .done_o       (done),
    .err_o        (err),
    .uart_addr_i  (uart_addr),
    .src_addr_o   (src_addr),
    .src_data_i   (src_data),
    .uart_data_o  (uart_data),
    .uart_start_o (uart_start),
    .uart_idle_i  (uart_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // source s byte at address a; source 1 holds "Hi\n\0"
  function automatic logic [7:0] src_byte(input int s, input logic [7:0] a);
    if (s == 1 && a < 8'd4) begin
      case (a)
        8'd0:    return 8'h48;
        8'd1:    return 8'h69;
        8'd2:    return 8'h0A;
        default: return 8'h00;
      endcase
    end
    return 8'((s * 37 + int'(a) * 11 + 5) ^ (int'(a) >> 2));
  endfunction

  always_comb begin
    src_data = '0;
    for (int s = 0; s < N; s++) src_data[8*s +: 8] = src_byte(s, src_addr);
  end

  // UART model: reacts to start one edge later, stays busy for busy_len cycles
  int ucnt;
  int busy_len;
  bit never_busy;

  initial begin
    logic st;
    uart_idle = 1'b1;
    uart_addr = '0;
    ucnt      = 0;
    forever begin
      @(negedge clk);
      st = uart_start;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ucnt      = 0;
        uart_idle = 1'b1;
        uart_addr = '0;
      end else if (ucnt > 0) begin
        ucnt--;
        uart_addr = uart_addr + 1'b1;
        if (ucnt == 0) uart_idle = 1'b1;
      end else if (st && !never_busy) begin
        ucnt      = busy_len;
        uart_addr = '0;
        uart_idle = 1'b0;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  // reference model phases: 0 free, 1 start requested, 2 uart busy, 3 finishing
  int m_phase;
  int m_g;
  int m_last;
  int m_cnt;
  bit m_err;

  int          done_cnt [N];
  int          err_cnt;
  int          start_cyc;
  int          gseq [$];
  logic [7:0]  data_q [$];
  logic [N-1:0] prev_grant;
  logic [N-1:0] eg;
  logic [N-1:0] ed;

  initial begin
    m_phase = 0; m_g = 0; m_last = N - 1; m_cnt = 0; m_err = 1'b0;
    prev_grant = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_last = N - 1; m_cnt = 0; m_err = 1'b0;
    end
    eg = (m_phase != 0) ? (N'(1) << m_g) : '0;
    ed = (m_phase == 3) ? eg : '0;
    check("grant", grant, eg);
    check("uart_start", uart_start, (m_phase == 1));
    check("done", done, ed);
    check("err", err, m_err);
    check("src_addr", src_addr, uart_addr);
    check("uart_data", uart_data, (m_phase != 0) ? src_byte(m_g, uart_addr) : 8'h00);
    check("onehot", ($countones(grant) <= 1), 1);

    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gseq.push_back(i);
    end
    for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
    if (err) err_cnt++;
    if (uart_start) start_cyc++;
    if (grant != '0 && !uart_idle) data_q.push_back(uart_data);
    prev_grant = grant;

    if (rst_n) begin
      m_err = 1'b0;
      case (m_phase)
        0: if (req != '0 && uart_idle) begin
             m_g = rr_pick(req, m_last);
             m_cnt = 0;
             m_phase = 1;
           end
        1: if (!uart_idle) m_phase = 2;
           else begin
             m_cnt++;
             if (m_cnt == BT) begin
               m_err = 1'b1;
               m_last = m_g;
               m_phase = 0;
             end
           end
        2: if (uart_idle) m_phase = 3;
        default: begin
          m_last = m_g;
          m_phase = 0;
        end
      endcase
    end
  end

  function automatic int total_done();
    int t = 0;
    for (int i = 0; i < N; i++) t += done_cnt[i];
    return t;
  endfunction

  function automatic int gat(input int k);
    if (k < gseq.size()) return gseq[k];
    return -1;
  endfunction

  function automatic int dat(input int k);
    if (k < data_q.size()) return int'(data_q[k]);
    return -1;
  endfunction

  function automatic int ev_count(input int kind);
    case (kind)
      0:       return total_done();
      1:       return err_cnt;
      2:       return gseq.size();
      default: return uart_idle ? 0 : 1;
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int n, input int budget, input string tag);
    int k = 0;
    while (ev_count(kind) < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_reached"}, (ev_count(kind) >= n), 1);
  endtask

  task automatic clear_log();
    gseq.delete();
    data_q.delete();
    err_cnt   = 0;
    start_cyc = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_start", uart_start, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n      = 1'b1;
    req        = '0;
    busy_len   = 4;
    never_busy = 1'b0;
    clear_log();
    #2;

    // single request
    do_reset();
    busy_len = 20;
    req = 4'b0100;
    @(posedge clk);
    #1;
    check("single_grant", grant, 4'b0100);
    check("single_start", uart_start, 1);
    wait_ev(0, 1, 200, "single_done");
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("single_done2", done_cnt[2], 1);
    check("single_ndone", total_done(), 1);
    check("single_ngrant", gseq.size(), 1);
    check("single_start_cyc", start_cyc, 2);
    check("single_grant_clr", grant, 0);

    // round robin with all sources requesting
    do_reset();
    busy_len = 3;
    req = 4'hF;
    wait_ev(0, 5, 400, "rr_done");
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rr_ngrant", gseq.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), gat(k), rr_exp[k]);
    check("rr_done0", done_cnt[0], 2);
    check("rr_done3", done_cnt[3], 1);

    // data mux from source 1
    do_reset();
    busy_len = 4;
    req = 4'b0010;
    wait_ev(0, 1, 100, "data_done");
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("data_len", data_q.size(), 4);
    check("data_b0", dat(0), 32'h48);
    check("data_b1", dat(1), 32'h69);
    check("data_b2", dat(2), 32'h0A);
    check("data_b3", dat(3), 32'h00);
    check("data_idle0", uart_data, 8'h00);

    // UART never goes busy
    do_reset();
    never_busy = 1'b1;
    req = 4'b0011;
    wait_ev(1, 1, 100, "tmo_err");
    check("tmo_errcnt", err_cnt, 1);
    check("tmo_nodone", total_done(), 0);
    check("tmo_start_cyc", start_cyc, BT);
    check("tmo_first", gat(0), 0);
    wait_ev(2, 2, 20, "tmo_regrant");
    check("tmo_next", gat(1), 1);
    req = '0;
    wait_ev(1, 2, 100, "tmo_err2");
    never_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("tmo_nodone2", total_done(), 0);

    // request dropped while the message is in flight
    do_reset();
    busy_len = 20;
    req = 4'b1000;
    wait_ev(3, 1, 20, "drop_busy");
    repeat (6) @(posedge clk);
    #1;
    check("drop_pre", grant, 4'b1000);
    req = '0;
    wait_ev(0, 1, 100, "drop_done");
    check("drop_done3", done_cnt[3], 1);

    // asynchronous reset in the middle of a message
    do_reset();
    busy_len = 30;
    req = 4'b0100;
    wait_ev(3, 1, 20, "ar_busy");
    repeat (4) @(posedge clk);
    #1;
    check("ar_pre", grant, 4'b0100);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_grant", grant, 0);
    check("ar_start", uart_start, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    check("ar_data", uart_data, 8'h00);
    req = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    wait_ev(2, 1, 20, "ar_regrant");
    check("ar_src3", gat(0), 3);
    wait_ev(0, 1, 100, "ar_fin");
    req = '0;

    // randomized traffic, checked cycle by cycle by the reference model
    do_reset();
    busy_len = 5;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 29) == 0) busy_len = $urandom_range(1, 12);
      if ($urandom_range(0, 59) == 0) never_busy = ($urandom_range(0, 3) == 0);
      @(posedge clk);
      #1;
    end
    req = '0;
    never_busy = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("rand_active", (gseq.size() > 10), 1);
    check("rand_settled", grant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
